// File: rtl/recon_dma_sequencer.sv
// recon_dma_sequencer
// Decodes a recon header carried in the first beat of each ingress frame and
// turns it into a read or write DMA descriptor. A write frame's payload is
// forwarded unmodified to the DMA write data path, and its byte count is
// checked against the header size. The number of descriptors that are still
// waiting for a completion status is limited to MAX_OUTSTANDING.
module recon_dma_sequencer #(
    parameter int DATA_WIDTH         = 512,
    parameter int KEEP_WIDTH         = DATA_WIDTH/8,
    parameter int ADDR_WIDTH         = 34,
    parameter int DMA_DESC_LEN_WIDTH = 20,
    parameter int DMA_DESC_TAG_WIDTH = 8,
    parameter int HDR_OFFSET         = 46,
    parameter int MAX_OUTSTANDING    = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [DATA_WIDTH-1:0]                  s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]                  s_axis_tkeep,
    input  logic                                   s_axis_tvalid,
    input  logic                                   s_axis_tlast,
    output logic                                   s_axis_tready,
    output logic [ADDR_WIDTH-1:0]                  m_axis_read_desc_addr,
    output logic [DMA_DESC_LEN_WIDTH-1:0]          m_axis_read_desc_len,
    output logic [DMA_DESC_TAG_WIDTH-1:0]          m_axis_read_desc_tag,
    output logic                                   m_axis_read_desc_valid,
    input  logic                                   m_axis_read_desc_ready,
    output logic [ADDR_WIDTH-1:0]                  m_axis_write_desc_addr,
    output logic [DMA_DESC_LEN_WIDTH-1:0]          m_axis_write_desc_len,
    output logic [DMA_DESC_TAG_WIDTH-1:0]          m_axis_write_desc_tag,
    output logic                                   m_axis_write_desc_valid,
    input  logic                                   m_axis_write_desc_ready,
    input  logic                                   s_axis_desc_status_valid,
    output logic [DATA_WIDTH-1:0]                  m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]                  m_axis_tkeep,
    output logic                                   m_axis_tvalid,
    output logic                                   m_axis_tlast,
    input  logic                                   m_axis_tready,
    output logic                                   stat_err_func,
    output logic                                   stat_err_len,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
    output logic                                   busy
);

    localparam int H  = HDR_OFFSET * 8;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);

    // The whole header has to be inside the first beat. Elaboration stops if it is not.
    if (H + 3 + ADDR_WIDTH + DMA_DESC_LEN_WIDTH > DATA_WIDTH) begin : g_bad_hdr_cfg
        $error("recon header does not fit inside the first beat");
    end
    if (MAX_OUTSTANDING < 1) begin : g_bad_out_cfg
        $error("MAX_OUTSTANDING must be at least 1");
    end

    typedef enum logic [2:0] {IDLE, WR_DESC, RD_DESC, XFER, DROP} state_e;

    state_e                          state_q, state_d;
    logic [ADDR_WIDTH-1:0]           addr_q, addr_d;
    logic [DMA_DESC_LEN_WIDTH-1:0]   size_q, size_d;
    logic                            hdr_last_q, hdr_last_d;
    logic [DMA_DESC_TAG_WIDTH-1:0]   tag_q, tag_d;
    logic [31:0]                     byte_cnt_q, byte_cnt_d;
    logic [OW-1:0]                   out_q, out_d;
    logic                            wr_valid_q, wr_valid_d;
    logic                            rd_valid_q, rd_valid_d;
    logic                            err_func_q, err_func_d;
    logic                            err_len_q, err_len_d;

    logic                            in_ready;
    logic                            s_hs, wr_hs, rd_hs, desc_hs, status_take;
    logic [31:0]                     xfer_sum;

    // Header fields sit at a fixed bit offset in the first beat.
    logic [1:0]                      hdr_func;
    logic                            hdr_size_valid;
    logic [ADDR_WIDTH-1:0]           hdr_addr;
    logic [DMA_DESC_LEN_WIDTH-1:0]   hdr_size;

    assign hdr_func       = s_axis_tdata[H +: 2];
    assign hdr_size_valid = s_axis_tdata[H + 2];
    assign hdr_addr       = s_axis_tdata[H + 3 +: ADDR_WIDTH];
    assign hdr_size       = s_axis_tdata[H + 3 + ADDR_WIDTH +: DMA_DESC_LEN_WIDTH];

    function automatic logic [31:0] popcount(input logic [KEEP_WIDTH-1:0] keep);
        logic [31:0] n;
        n = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) n = n + 32'(keep[i]);
        return n;
    endfunction

    // Ingress ready and handshake qualifiers. Ready is forced low while reset is asserted.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        in_ready = 1'b0;
        unique case (state_q)
            IDLE:    in_ready = (out_q < MAX_OUT);
            XFER:    in_ready = m_axis_tready;
            DROP:    in_ready = 1'b1;
            default: in_ready = 1'b0;
        endcase
        s_axis_tready = in_ready & ~rst;
        s_hs          = s_axis_tvalid & s_axis_tready;
        wr_hs         = wr_valid_q & m_axis_write_desc_ready;
        rd_hs         = rd_valid_q & m_axis_read_desc_ready;
        desc_hs       = wr_hs | rd_hs;
        // A status that arrives while the count is already zero is ignored.
        status_take   = s_axis_desc_status_valid & (out_q != '0);
    end

    // Next-state logic: header decode, descriptor issue, payload accounting and the outstanding count.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        size_d     = size_q;
        hdr_last_d = hdr_last_q;
        tag_d      = tag_q;
        byte_cnt_d = byte_cnt_q;
        out_d      = out_q;
        wr_valid_d = wr_valid_q;
        rd_valid_d = rd_valid_q;
        err_func_d = 1'b0;
        err_len_d  = 1'b0;
        xfer_sum   = byte_cnt_q + popcount(s_axis_tkeep);

        unique case (state_q)
            IDLE: begin
                if (s_hs) begin
                    addr_d     = hdr_addr;
                    size_d     = hdr_size;
                    hdr_last_d = s_axis_tlast;
                    if (!hdr_size_valid || hdr_func == 2'b11) begin
                        err_func_d = 1'b1;
                        state_d    = s_axis_tlast ? IDLE : DROP;
                    end else if (hdr_func == 2'b00) begin
                        // A write header with no payload after it is a length error.
                        if (s_axis_tlast) begin
                            err_len_d = 1'b1;
                        end else begin
                            state_d    = WR_DESC;
                            wr_valid_d = 1'b1;
                        end
                    end else if (hdr_func == 2'b01) begin
                        state_d    = RD_DESC;
                        rd_valid_d = 1'b1;
                    end else begin
                        state_d = s_axis_tlast ? IDLE : DROP;
                    end
                end
            end
            WR_DESC: begin
                if (wr_hs) begin
                    wr_valid_d = 1'b0;
                    byte_cnt_d = '0;
                    state_d    = XFER;
                end
            end
            RD_DESC: begin
                if (rd_hs) begin
                    rd_valid_d = 1'b0;
                    state_d    = hdr_last_q ? IDLE : DROP;
                end
            end
            XFER: begin
                if (s_hs) begin
                    byte_cnt_d = xfer_sum;
                    if (s_axis_tlast) begin
                        err_len_d = (xfer_sum != 32'(size_q));
                        state_d   = IDLE;
                    end
                end
            end
            DROP: begin
                if (s_hs && s_axis_tlast) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (desc_hs) tag_d = tag_q + 1'b1;

        if (desc_hs && !status_take)      out_d = out_q + 1'b1;
        else if (!desc_hs && status_take) out_d = out_q - 1'b1;
    end

    // All sequencer state and registered outputs. Reset is asynchronous.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            size_q     <= '0;
            hdr_last_q <= 1'b0;
            tag_q      <= '0;
            byte_cnt_q <= '0;
            out_q      <= '0;
            wr_valid_q <= 1'b0;
            rd_valid_q <= 1'b0;
            err_func_q <= 1'b0;
            err_len_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
            state_q    <= state_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            hdr_last_q <= hdr_last_d;
            tag_q      <= tag_d;
            byte_cnt_q <= byte_cnt_d;
            out_q      <= out_d;
            wr_valid_q <= wr_valid_d;
            rd_valid_q <= rd_valid_d;
            err_func_q <= err_func_d;
            err_len_q  <= err_len_d;
        end
    end

    // The payload goes straight through with no latency. Only valid is gated to the XFER state.
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tkeep  = s_axis_tkeep;
    assign m_axis_tlast  = s_axis_tlast;
    assign m_axis_tvalid = (state_q == XFER) & s_axis_tvalid;

    // Both descriptor channels carry the latched header. Only one channel's valid is ever high.
    assign m_axis_write_desc_addr  = addr_q;
    assign m_axis_write_desc_len   = size_q;
    assign m_axis_write_desc_tag   = tag_q;
    assign m_axis_write_desc_valid = wr_valid_q;
    assign m_axis_read_desc_addr   = addr_q;
    assign m_axis_read_desc_len    = size_q;
    assign m_axis_read_desc_tag    = tag_q;
    assign m_axis_read_desc_valid  = rd_valid_q;

    assign stat_err_func = err_func_q;
    assign stat_err_len  = err_len_q;
    assign outstanding   = out_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_recon_dma_sequencer.sv
// Directed testbench for recon_dma_sequencer. Every expected value is worked out by hand from the header contents.
module tb_recon_dma_sequencer;

    localparam int DW   = 512;
    localparam int KW   = DW / 8;
    localparam int AW   = 34;
    localparam int LW   = 20;
    localparam int TW   = 8;
    localparam int HOFF = 46;
    localparam int MAXO = 4;
    localparam int OW   = $clog2(MAXO + 1);
    localparam int H    = HOFF * 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [DW-1:0]   s_axis_tdata = '0;
    logic [KW-1:0]   s_axis_tkeep = '0;
    logic            s_axis_tvalid = 1'b0;
    logic            s_axis_tlast = 1'b0;
    logic            s_axis_tready;
    logic [AW-1:0]   rd_addr, wr_addr;
    logic [LW-1:0]   rd_len, wr_len;
    logic [TW-1:0]   rd_tag, wr_tag;
    logic            rd_valid, wr_valid;
    logic            rd_ready = 1'b0;
    logic            wr_ready = 1'b0;
    logic            status = 1'b0;
    logic [DW-1:0]   m_axis_tdata;
    logic [KW-1:0]   m_axis_tkeep;
    logic            m_axis_tvalid, m_axis_tlast;
    logic            m_axis_tready = 1'b1;
    logic            err_func, err_len;
    logic [OW-1:0]   outstanding;
    logic            busy;

    int              total = 0;
    int              bad   = 0;
    logic [TW-1:0]   exp_tag = '0;

    localparam logic [KW-1:0] KEEP_ALL  = {KW{1'b1}};
    localparam logic [KW-1:0] KEEP_HALF = {{(KW/2){1'b0}}, {(KW/2){1'b1}}};

    recon_dma_sequencer #(
        .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ADDR_WIDTH(AW), .DMA_DESC_LEN_WIDTH(LW),
        .DMA_DESC_TAG_WIDTH(TW), .HDR_OFFSET(HOFF), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_axis_read_desc_addr(rd_addr), .m_axis_read_desc_len(rd_len), .m_axis_read_desc_tag(rd_tag),
        .m_axis_read_desc_valid(rd_valid), .m_axis_read_desc_ready(rd_ready),
        .m_axis_write_desc_addr(wr_addr), .m_axis_write_desc_len(wr_len), .m_axis_write_desc_tag(wr_tag),
        .m_axis_write_desc_valid(wr_valid), .m_axis_write_desc_ready(wr_ready),
        .s_axis_desc_status_valid(status),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .stat_err_func(err_func), .stat_err_len(err_len), .outstanding(outstanding), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [DW-1:0] make_hdr(input logic [1:0] func, input logic sv,
                                               input logic [AW-1:0] addr, input logic [LW-1:0] size);
        logic [DW-1:0] d;
        d = {16{32'hA5A5_5A5A}};
        d[H +: 2]       = func;
        d[H + 2]        = sv;
        d[H + 3 +: AW]  = addr;
        d[H + 3 + AW +: LW] = size;
        return d;
    endfunction

    function automatic logic [DW-1:0] pay(input int i);
        return {16{32'(i) ^ 32'hC0DE_0000}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_status();
        status = 1'b1;
        step();
        status = 1'b0;
    endtask

    // Offers one beat and waits, within a bound, for it to be accepted. The task is entered and left one tick after a clock edge.
    // mode 1: the beat must pass straight through to m_axis. mode 2: it must not appear on m_axis.
    task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l, input int mode);
        int n;
        n = 0;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        #1;
        while (!s_axis_tready && n < 50) begin
            step();
            n++;
        end
        total++;
        if (s_axis_tready !== 1'b1) begin
            bad++;
            $display("FAIL beat_accept: tready=%b after %0d cycles, required 1", s_axis_tready, n);
        end
        if (mode == 1) begin
            total++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== d || m_axis_tkeep !== k || m_axis_tlast !== l) begin
                bad++;
                $display("FAIL pass_through: tvalid=%b tkeep=%h tlast=%b, required 1/%h/%b", m_axis_tvalid, m_axis_tkeep, m_axis_tlast, k, l);
            end
        end else if (mode == 2) begin
            total++;
            if (m_axis_tvalid !== 1'b0) begin
                bad++;
                $display("FAIL drop_no_forward: m_axis_tvalid=%b required 0", m_axis_tvalid);
            end
        end
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_axis_tdata = make_hdr(2'b01, 1'b1, 34'h0_0000_0040, 20'd64);
        s_axis_tkeep = KEEP_ALL;
        s_axis_tlast = 1'b1;
        s_axis_tvalid = 1'b1;
        step();
        step();
        total++; if (s_axis_tready !== 1'b0) begin bad++; $display("FAIL reset_tready: got %b want 0", s_axis_tready); end
        total++; if (rd_valid !== 1'b0 || wr_valid !== 1'b0) begin bad++; $display("FAIL reset_desc_valid: rd=%b wr=%b want 0", rd_valid, wr_valid); end
        total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL reset_m_tvalid: got %b want 0", m_axis_tvalid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (outstanding !== '0) begin bad++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
        total++; if (err_func !== 1'b0 || err_len !== 1'b0) begin bad++; $display("FAIL reset_err: func=%b len=%b want 0", err_func, err_len); end
        total++; if (wr_addr !== '0 || rd_len !== '0 || wr_tag !== '0) begin bad++; $display("FAIL reset_fields: addr=%h len=%h tag=%h want 0", wr_addr, rd_len, wr_tag); end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        rst = 1'b0;
        step();
        total++; if (s_axis_tready !== 1'b1) begin bad++; $display("FAIL idle_tready: got %b want 1", s_axis_tready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_write();
        wr_ready = 1'b0;
        send_beat(make_hdr(2'b00, 1'b1, 34'h1_0000_0000, 20'd128), KEEP_ALL, 1'b0, 0);
        total++; if (wr_valid !== 1'b1) begin bad++; $display("FAIL wr_valid: got %b want 1", wr_valid); end
        total++; if (wr_addr !== 34'h1_0000_0000) begin bad++; $display("FAIL wr_addr: got %h want 100000000", wr_addr); end
        total++; if (wr_len !== 20'd128) begin bad++; $display("FAIL wr_len: got %0d want 128", wr_len); end
        total++; if (wr_tag !== exp_tag) begin bad++; $display("FAIL wr_tag: got %0d want %0d", wr_tag, exp_tag); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL wr_no_read: rd_valid=%b want 0", rd_valid); end
        total++; if (s_axis_tready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL wr_desc_state: tready=%b busy=%b want 0/1", s_axis_tready, busy); end
        wr_ready = 1'b1;
        step();
        wr_ready = 1'b0;
        exp_tag++;
        total++; if (wr_valid !== 1'b0) begin bad++; $display("FAIL wr_valid_drop: got %b want 0", wr_valid); end
        total++; if (outstanding !== 3'd1) begin bad++; $display("FAIL wr_outstanding: got %0d want 1", outstanding); end
        send_beat(pay(1), KEEP_ALL, 1'b0, 1);
        send_beat(pay(2), KEEP_ALL, 1'b1, 1);
        total++; if (err_len !== 1'b0 || err_func !== 1'b0) begin bad++; $display("FAIL wr_no_err: len=%b func=%b want 0", err_len, err_func); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL wr_back_idle: busy=%b want 0", busy); end
        total++; if (outstanding !== 3'd1) begin bad++; $display("FAIL wr_outstanding_hold: got %0d want 1", outstanding); end
        pulse_status();
        total++; if (outstanding !== 3'd0) begin bad++; $display("FAIL wr_status: got %0d want 0", outstanding); end
    endtask

    task automatic test_read();
        rd_ready = 1'b0;
        send_beat(make_hdr(2'b01, 1'b1, 34'h0_2345_6780, 20'd4096), KEEP_ALL, 1'b1, 0);
        for (int i = 0; i < 5; i++) begin
            total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL rd_valid_hold[%0d]: got %b want 1", i, rd_valid); end
            total++; if (rd_len !== 20'd4096 || rd_addr !== 34'h0_2345_6780) begin bad++; $display("FAIL rd_fields_hold[%0d]: len=%0d addr=%h", i, rd_len, rd_addr); end
            total++; if (rd_tag !== exp_tag) begin bad++; $display("FAIL rd_tag[%0d]: got %0d want %0d", i, rd_tag, exp_tag); end
            step();
        end
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        exp_tag++;
        total++; if (rd_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rd_done: valid=%b busy=%b want 0/0", rd_valid, busy); end
        total++; if (outstanding !== 3'd1) begin bad++; $display("FAIL rd_outstanding: got %0d want 1", outstanding); end
        pulse_status();
        total++; if (outstanding !== 3'd0) begin bad++; $display("FAIL rd_status: got %0d want 0", outstanding); end
    endtask

    task automatic test_len_mismatch();
        wr_ready = 1'b1;
        send_beat(make_hdr(2'b00, 1'b1, 34'h0_0000_1000, 20'd200), KEEP_ALL, 1'b0, 0);
        send_beat(pay(10), KEEP_ALL, 1'b0, 1);
        wr_ready = 1'b0;
        exp_tag++;
        send_beat(pay(11), KEEP_ALL, 1'b0, 1);
        send_beat(pay(12), KEEP_HALF, 1'b0, 1);
        total++; if (err_len !== 1'b0) begin bad++; $display("FAIL len_early: err_len=%b want 0", err_len); end
        send_beat(pay(13), KEEP_HALF, 1'b1, 1);
        total++; if (err_len !== 1'b1) begin bad++; $display("FAIL len_pulse: err_len=%b want 1", err_len); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL len_idle: busy=%b want 0", busy); end
        step();
        total++; if (err_len !== 1'b0) begin bad++; $display("FAIL len_once: err_len=%b want 0", err_len); end
        pulse_status();
        total++; if (outstanding !== 3'd0) begin bad++; $display("FAIL len_status: got %0d want 0", outstanding); end
    endtask

    task automatic test_bad_header();
        send_beat(make_hdr(2'b11, 1'b1, 34'h0_0000_2000, 20'd64), KEEP_ALL, 1'b0, 0);
        total++; if (err_func !== 1'b1) begin bad++; $display("FAIL func_pulse: got %b want 1", err_func); end
        total++; if (wr_valid !== 1'b0 || rd_valid !== 1'b0) begin bad++; $display("FAIL func_no_desc: wr=%b rd=%b want 0", wr_valid, rd_valid); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL func_drop_busy: got %b want 1", busy); end
        send_beat(pay(20), KEEP_ALL, 1'b0, 2);
        total++; if (err_func !== 1'b0) begin bad++; $display("FAIL func_once: got %b want 0", err_func); end
        send_beat(pay(21), KEEP_ALL, 1'b1, 2);
        total++; if (busy !== 1'b0 || outstanding !== 3'd0) begin bad++; $display("FAIL func_done: busy=%b out=%0d want 0/0", busy, outstanding); end
        total++; if (wr_valid !== 1'b0 || rd_valid !== 1'b0) begin bad++; $display("FAIL func_no_desc_end: wr=%b rd=%b want 0", wr_valid, rd_valid); end
        // A clear size_valid flag marks the header bad even when func says write.
        send_beat(make_hdr(2'b00, 1'b0, 34'h0_0000_3000, 20'd64), KEEP_ALL, 1'b1, 0);
        total++; if (err_func !== 1'b1 || busy !== 1'b0 || wr_valid !== 1'b0) begin bad++; $display("FAIL sv0: func=%b busy=%b wr=%b want 1/0/0", err_func, busy, wr_valid); end
        // func=10 is silently ignored.
        send_beat(make_hdr(2'b10, 1'b1, 34'h0_0000_3000, 20'd64), KEEP_ALL, 1'b1, 0);
        total++; if (err_func !== 1'b0 || err_len !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL func10: func=%b len=%b busy=%b want 0/0/0", err_func, err_len, busy); end
        // A write header with tlast set has no payload, so it is a length error.
        send_beat(make_hdr(2'b00, 1'b1, 34'h0_0000_3000, 20'd64), KEEP_ALL, 1'b1, 0);
        total++; if (err_len !== 1'b1 || wr_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL wr_tlast: len=%b wr=%b busy=%b want 1/0/0", err_len, wr_valid, busy); end
    endtask

    task automatic test_backpressure();
        rd_ready = 1'b1;
        for (int i = 0; i < MAXO; i++) begin
            send_beat(make_hdr(2'b01, 1'b1, 34'(i * 64), 20'd64), KEEP_ALL, 1'b1, 0);
            step();
            exp_tag++;
        end
        rd_ready = 1'b0;
        total++; if (outstanding !== 3'd4) begin bad++; $display("FAIL bp_full: got %0d want 4", outstanding); end
        for (int i = 0; i < 3; i++) begin
            total++; if (s_axis_tready !== 1'b0) begin bad++; $display("FAIL bp_tready[%0d]: got %b want 0", i, s_axis_tready); end
            step();
        end
        status = 1'b1;
        #1;
        total++; if (s_axis_tready !== 1'b0) begin bad++; $display("FAIL bp_status_cycle: tready=%b want 0", s_axis_tready); end
        step();
        status = 1'b0;
        total++; if (outstanding !== 3'd3 || s_axis_tready !== 1'b1) begin bad++; $display("FAIL bp_release: out=%0d tready=%b want 3/1", outstanding, s_axis_tready); end
        for (int i = 0; i < 3; i++) pulse_status();
        total++; if (outstanding !== 3'd0) begin bad++; $display("FAIL bp_drain: got %0d want 0", outstanding); end
    endtask

    task automatic test_simultaneous();
        pulse_status();
        total++; if (outstanding !== 3'd0) begin bad++; $display("FAIL status_at_zero: got %0d want 0", outstanding); end
        rd_ready = 1'b1;
        send_beat(make_hdr(2'b01, 1'b1, 34'h0_0000_8000, 20'd32), KEEP_ALL, 1'b1, 0);
        step();
        exp_tag++;
        rd_ready = 1'b0;
        send_beat(make_hdr(2'b01, 1'b1, 34'h0_0000_9000, 20'd32), KEEP_ALL, 1'b1, 0);
        total++; if (outstanding !== 3'd1 || rd_valid !== 1'b1) begin bad++; $display("FAIL sim_setup: out=%0d rd=%b want 1/1", outstanding, rd_valid); end
        rd_ready = 1'b1;
        status   = 1'b1;
        step();
        rd_ready = 1'b0;
        status   = 1'b0;
        exp_tag++;
        total++; if (outstanding !== 3'd1 || rd_valid !== 1'b0) begin bad++; $display("FAIL sim_unchanged: out=%0d rd=%b want 1/0", outstanding, rd_valid); end
        pulse_status();
        total++; if (outstanding !== 3'd0) begin bad++; $display("FAIL sim_drain: got %0d want 0", outstanding); end
    endtask

    task automatic test_async_reset();
        wr_ready = 1'b1;
        send_beat(make_hdr(2'b00, 1'b1, 34'h0_0000_A000, 20'd128), KEEP_ALL, 1'b0, 0);
        send_beat(pay(30), KEEP_ALL, 1'b0, 1);
        wr_ready = 1'b0;
        s_axis_tdata  = pay(31);
        s_axis_tkeep  = KEEP_ALL;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b1;
        #1;
        total++; if (m_axis_tvalid !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL ar_in_xfer: tvalid=%b busy=%b want 1/1", m_axis_tvalid, busy); end
        #1 rst = 1'b1;
        #1;
        total++; if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b0) begin bad++; $display("FAIL ar_data: m_tvalid=%b tready=%b want 0/0", m_axis_tvalid, s_axis_tready); end
        total++; if (busy !== 1'b0 || outstanding !== 3'd0) begin bad++; $display("FAIL ar_state: busy=%b out=%0d want 0/0", busy, outstanding); end
        total++; if (wr_tag !== '0 || wr_addr !== '0 || wr_valid !== 1'b0) begin bad++; $display("FAIL ar_desc: tag=%0d addr=%h valid=%b want 0", wr_tag, wr_addr, wr_valid); end
        step();
        s_axis_tvalid = 1'b0;
        rst = 1'b0;
        exp_tag = '0;
        rd_ready = 1'b0;
        send_beat(make_hdr(2'b01, 1'b1, 34'h0_0000_B000, 20'd16), KEEP_ALL, 1'b1, 0);
        total++; if (rd_valid !== 1'b1 || rd_tag !== exp_tag || rd_len !== 20'd16) begin bad++; $display("FAIL ar_header_after: rd=%b tag=%0d len=%0d want 1/0/16", rd_valid, rd_tag, rd_len); end
        total++; if (err_len !== 1'b0 || err_func !== 1'b0) begin bad++; $display("FAIL ar_no_err: len=%b func=%b want 0", err_len, err_func); end
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        exp_tag++;
        pulse_status();
    endtask

    task automatic test_tag_wrap();
        // One descriptor has been issued since the last reset. 255 more bring the tag counter back to zero.
        rd_ready = 1'b1;
        for (int i = 0; i < 255; i++) begin
            send_beat(make_hdr(2'b01, 1'b1, 34'(i), 20'd8), KEEP_ALL, 1'b1, 0);
            total++; if (rd_tag !== exp_tag || rd_valid !== 1'b1) begin bad++; $display("FAIL wrap_tag[%0d]: tag=%0d valid=%b want %0d/1", i, rd_tag, rd_valid, exp_tag); end
            step();
            exp_tag++;
            pulse_status();
        end
        send_beat(make_hdr(2'b01, 1'b1, 34'h0_0000_C000, 20'd8), KEEP_ALL, 1'b1, 0);
        total++; if (rd_tag !== 8'd0) begin bad++; $display("FAIL wrap_zero: tag=%0d want 0", rd_tag); end
        step();
        rd_ready = 1'b0;
        pulse_status();
        total++; if (outstanding !== 3'd0 || busy !== 1'b0) begin bad++; $display("FAIL wrap_end: out=%0d busy=%b want 0/0", outstanding, busy); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_len_mismatch();
        test_bad_header();
        test_backpressure();
        test_simultaneous();
        test_async_reset();
        test_tag_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/recon_dma_sequencer.md
RECON_DMA_SEQUENCER -- requirements
Module: recon_dma_sequencer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  DATA_WIDTH, 512, stream width in bits (multiple of 8).
  KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
  ADDR_WIDTH, 34, DMA address width.
  DMA_DESC_LEN_WIDTH, 20, descriptor length width.
  DMA_DESC_TAG_WIDTH, 8, descriptor tag width.
  HDR_OFFSET, 46, byte offset of the recon header in the first beat.
  MAX_OUTSTANDING, 4, maximum number of descriptors awaiting status (at least 1).
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk  in  1  clock.
  rst  in  1  reset; asynchronous, active-high.
  s_axis_tdata/tkeep/tvalid/tlast  in  DATA_WIDTH/KEEP_WIDTH/1/1  ingress frames.
  s_axis_tready  out  1  ingress ready.
  m_axis_read_desc_addr/len/tag  out  ADDR_WIDTH/DMA_DESC_LEN_WIDTH/DMA_DESC_TAG_WIDTH  read descriptor fields.
  m_axis_read_desc_valid  out  1  read descriptor valid.
  m_axis_read_desc_ready  in  1  read descriptor ready.
  m_axis_write_desc_addr/len/tag  out  ADDR_WIDTH/DMA_DESC_LEN_WIDTH/DMA_DESC_TAG_WIDTH  write descriptor fields.
  m_axis_write_desc_valid  out  1  write descriptor valid.
  m_axis_write_desc_ready  in  1  write descriptor ready.
  s_axis_desc_status_valid  in  1  one-cycle completion pulse, one per issued descriptor (read or write).
  m_axis_tdata/tkeep/tvalid/tlast  out  DATA_WIDTH/KEEP_WIDTH/1/1  payload toward DMA write data path.
  m_axis_tready  in  1  payload ready.
  stat_err_func  out  1  one-cycle pulse on a bad header.
  stat_err_len  out  1  one-cycle pulse on a length mismatch.
  outstanding  out  $clog2(MAX_OUTSTANDING+1)  descriptors awaiting status.
  busy  out  1  high whenever the state is not IDLE.

Function
REQ-003 Header fields, bit base H=HDR_OFFSET*8 of the first beat:
  - func [H+1:H]
  - size_valid [H+2]
  - addr [H+3 +: ADDR_WIDTH]
  - size [H+3+ADDR_WIDTH +: DMA_DESC_LEN_WIDTH]
REQ-004 The configuration SHALL satisfy H+3+ADDR_WIDTH+DMA_DESC_LEN_WIDTH <= DATA_WIDTH; elaboration SHALL fail otherwise.
REQ-005 States SHALL be IDLE, WR_DESC, RD_DESC, XFER and DROP.
REQ-006 In IDLE, s_axis_tready SHALL be 1 iff outstanding < MAX_OUTSTANDING; an accepted beat is the header beat, and addr/size SHALL be latched at that handshake.
REQ-007 Header decode (a header-beat tlast means no further beats of that frame follow):
  - size_valid=0, or func=11: pulse stat_err_func, no descriptor; next state IDLE if tlast, else DROP.
  - func=00 with tlast: pulse stat_err_len, no descriptor, next state IDLE.
  - func=00 without tlast: next state WR_DESC.
  - func=01: next state RD_DESC.
  - func=10: no descriptor; next state IDLE if tlast, else DROP.
REQ-008 In WR_DESC and RD_DESC, the respective desc_valid SHALL assert on the cycle after entry, with fields held stable until ready.
  - addr = latched addr; len = latched size; tag = tag counter.
REQ-009 On a descriptor handshake, valid SHALL drop on the next cycle and the tag counter SHALL increment, wrapping modulo 2^DMA_DESC_TAG_WIDTH.
  - WR_DESC then goes to XFER.
  - RD_DESC then goes to IDLE if the header beat had tlast, else to DROP.
REQ-010 In XFER:
  - m_axis_t* SHALL equal s_axis_t*, with m_axis_tvalid = s_axis_tvalid and s_axis_tready = m_axis_tready (zero latency).
  - A 32-bit byte counter, cleared on XFER entry, SHALL add popcount(tkeep) per handshake.
REQ-011 On the tlast handshake in XFER, stat_err_len SHALL pulse on the next cycle if (counter + that beat's bytes) != latched size; the next state is IDLE.
REQ-012 In DROP, s_axis_tready SHALL be 1 and beats are discarded; the next state is IDLE on the tlast handshake.
REQ-013 Outside XFER, m_axis_tvalid SHALL be 0.
REQ-014 The outstanding counter SHALL update each cycle:
  - +1 on any descriptor handshake.
  - -1 on s_axis_desc_status_valid.
  - Unchanged when both occur in the same cycle.
  - Status while at 0 SHALL be ignored (saturate at 0).
REQ-015 A header SHALL NOT be accepted while outstanding = MAX_OUTSTANDING; a header accepted in the same cycle a status arrives at the limit is not allowed (the check uses the registered value).

Reset
REQ-016 While rst is high, regardless of clk:
  - state = IDLE; tag counter, byte counter and outstanding = 0.
  - desc valids, m_axis_tvalid, stat_err_func, stat_err_len and busy = 0.
  - desc fields = 0; s_axis_tready = 0.
REQ-017 Reset mid-frame SHALL abandon the frame with no descriptor or error pulse; the next beat accepted after release is treated as a header.

Verification
REQ-018 Write then payload: func=00, size=128, addr=0x1_0000_0000, header beat plus 2 beats with 64 bytes each, the second with tlast.
  - Write descriptor: addr 0x1_0000_0000, len 128, tag 0.
  - Both payload beats appear on m_axis unchanged; no error pulse; outstanding = 1 until the status pulse.
REQ-019 Read request: single-beat func=01 frame, size=4096.
  - Read descriptor with len 4096, tag incremented after a prior write.
  - m_axis_desc_ready held low 5 cycles: valid and fields held stable throughout.
REQ-020 Length mismatch: func=00, size=200, payload totalling 192 bytes.
  - stat_err_len pulses once, one cycle after tlast; state returns to IDLE.
REQ-021 Bad header and backpressure:
  - func=11, 3-beat frame: stat_err_func pulses, all beats dropped, no descriptor.
  - MAX_OUTSTANDING=4 with 4 descriptors pending: s_axis_tready = 0 until one status pulse arrives.
REQ-022 Tag wrap and simultaneous events:
  - 256 descriptors with DMA_DESC_TAG_WIDTH=8: tag returns to 0.
  - Handshake and status in the same cycle: outstanding unchanged.
  - Async rst asserted in XFER: outputs clear immediately.
